// File: rtl/dmem_byte_ctrl.sv
// Byte-addressable RV32 data memory with fixed-latency request/response handshake.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned half/word accesses instead of force-aligning them.
module dmem_byte_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, next_state;
    logic [2:0]  cnt, next_cnt;
    logic        accept;

    logic        write_p0;
    logic [2:0]  funct3_p0;
    logic [AW+1:0] addr_p0;
    logic [31:0] wdata_p0;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] word;
    logic [3:0]  byte_en;
    logic [31:0] wlanes;
    logic        err;
    logic        addr_hi_unused;

    // Address bits above the array wrap silently.
    assign addr_hi_unused = ^req_addr[31:AW+2];

    function automatic logic bad_funct3(input logic wr, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: return 1'b0;
            3'b100, 3'b101:         return wr;
            default:                return 1'b1;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
`ifdef DMEM_MISALIGN_ERR_EN
        return (f3[1:0] == 2'b01 && lane[0]) || (f3[1:0] == 2'b10 && lane != 2'b00);
`else
        return 1'b0 & ^{f3, lane};
`endif
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lane);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = $signed(w[{lane, 3'b000} +: 8]);
        h = $signed(lane[1] ? w[31:16] : w[15:0]);
        case (f3)
            3'b000:  return 32'(b);
            3'b100:  return {24'b0, b};
            3'b001:  return 32'(h);
            3'b101:  return {16'b0, h};
            3'b010:  return w;
            default: return 32'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY > 1) begin
                        next_state = WAIT;
                        next_cnt   = 3'(LATENCY - 1);
                    end else begin
                        next_state = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 3'd1) begin
                    next_state = RESP;
                    next_cnt   = 3'd0;
                end else begin
                    next_cnt = cnt - 3'd1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // p0: request captured at accept, held until the response completes
    always_ff @(posedge clk) begin
        if (accept) begin
            write_p0  <= req_write;
            funct3_p0 <= req_funct3;
            addr_p0   <= req_addr[AW+1:0];
            wdata_p0  <= req_wdata;
        end
    end

    assign word    = mem[addr_p0[AW+1:2]];
    assign err     = bad_funct3(write_p0, funct3_p0) | misaligned(funct3_p0, addr_p0[1:0]);
    assign byte_en = store_be(funct3_p0, addr_p0[1:0]);

    always_comb begin
        case (funct3_p0[1:0])
            2'b00:   wlanes = {4{wdata_p0[7:0]}};
            2'b01:   wlanes = {2{wdata_p0[15:0]}};
            default: wlanes = wdata_p0;
        endcase
    end

    // Store commits on the edge that ends RESP; reset before then drops it.
    always_ff @(posedge clk) begin
        if (state == RESP && write_p0 && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[addr_p0[AW+1:2]][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid & err;
    assign rsp_rdata = (rsp_valid && !err && !write_p0) ?
                       load_ext(word, funct3_p0, addr_p0[1:0]) : 32'b0;

endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// Directed bench for dmem_byte_ctrl: three instances at LATENCY 1, 3 and 2.
module tb_dmem_byte_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_a  [3];
    logic        req_ready_a  [3];
    logic        req_write_a  [3];
    logic [2:0]  req_funct3_a [3];
    logic [31:0] req_addr_a   [3];
    logic [31:0] req_wdata_a  [3];
    logic        rsp_valid_a  [3];
    logic [31:0] rsp_rdata_a  [3];
    logic        rsp_err_a    [3];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int lat_of [3] = '{1, 3, 2};

`ifdef DMEM_MISALIGN_ERR_EN
    localparam logic        MIS_ERR  = 1'b1;
    localparam logic [31:0] LH103    = 32'h0;
    localparam logic [31:0] LW101    = 32'h0;
    localparam logic [31:0] WORD_FIN = 32'h8001_1234;
`else
    localparam logic        MIS_ERR  = 1'b0;
    localparam logic [31:0] LH103    = 32'hFFFF_8001;
    localparam logic [31:0] LW101    = 32'h8001_1234;
    localparam logic [31:0] WORD_FIN = 32'h8001_BEEF;
`endif

    always #5 clk = ~clk;

    dmem_byte_ctrl #(.DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]), .req_write(req_write_a[0]),
        .req_funct3(req_funct3_a[0]), .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]),
        .rsp_valid(rsp_valid_a[0]), .rsp_rdata(rsp_rdata_a[0]), .rsp_err(rsp_err_a[0])
    );

    dmem_byte_ctrl #(.DEPTH_WORDS(1024), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]), .req_write(req_write_a[1]),
        .req_funct3(req_funct3_a[1]), .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]),
        .rsp_valid(rsp_valid_a[1]), .rsp_rdata(rsp_rdata_a[1]), .rsp_err(rsp_err_a[1])
    );

    dmem_byte_ctrl #(.DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a[2]), .req_ready(req_ready_a[2]), .req_write(req_write_a[2]),
        .req_funct3(req_funct3_a[2]), .req_addr(req_addr_a[2]), .req_wdata(req_wdata_a[2]),
        .rsp_valid(rsp_valid_a[2]), .rsp_rdata(rsp_rdata_a[2]), .rsp_err(rsp_err_a[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on instance d; inputs are scrambled right after acceptance.
    task automatic xact(input int d, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        req_valid_a[d]  = 1'b1;
        req_write_a[d]  = wr;
        req_funct3_a[d] = f3;
        req_addr_a[d]   = addr;
        req_wdata_a[d]  = wdata;
        @(posedge clk);
        #1;
        req_valid_a[d]  = 1'b0;
        req_write_a[d]  = ~wr;
        req_funct3_a[d] = 3'b010;
        req_addr_a[d]   = $urandom;
        req_wdata_a[d]  = $urandom;
        lat   = 0;
        rdata = 32'hx;
        err   = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (rsp_valid_a[d]) begin
                lat   = c;
                rdata = rsp_rdata_a[d];
                err   = rsp_err_a[d];
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic op(input string tag, input int d, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        xact(d, wr, f3, addr, wdata, rdata, err, lat);
        check({tag, ".lat"}, 32'(lat), 32'(lat_of[d]));
        check({tag, ".rdata"}, rdata, exp_rdata);
        check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid_a[i]  = 1'b0;
            req_write_a[i]  = 1'b0;
            req_funct3_a[i] = 3'b0;
            req_addr_a[i]   = 32'b0;
            req_wdata_a[i]  = 32'b0;
        end
        req_valid_a[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.ready",  {31'b0, req_ready_a[0]}, 32'd1);
        check("rst.valid",  {31'b0, rsp_valid_a[0]}, 32'd0);
        check("rst.rdata",  rsp_rdata_a[0], 32'd0);
        check("rst.err",    {31'b0, rsp_err_a[0]}, 32'd0);
        check("rst.ready3", {31'b0, req_ready_a[1]}, 32'd1);
        req_valid_a[0] = 1'b0;
        rst = 1'b0;

        // LATENCY=1 instance
        op("sw100",   0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0);
        op("lw100",   0, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0);
        op("sb101",   0, 1'b1, 3'b000, 32'h101, 32'h1234_5680, 32'h0, 1'b0);
        op("lb101",   0, 1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFF_FF80, 1'b0);
        op("lbu101",  0, 1'b0, 3'b100, 32'h101, 32'h0, 32'h0000_0080, 1'b0);
        op("lw100b",  0, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_80EF, 1'b0);
        op("sh102",   0, 1'b1, 3'b001, 32'h102, 32'hABCD_1234, 32'h0, 1'b0);
        op("lhu102",  0, 1'b0, 3'b101, 32'h102, 32'h0, 32'h0000_1234, 1'b0);
        op("lh100",   0, 1'b0, 3'b001, 32'h100, 32'h0, 32'hFFFF_80EF, 1'b0);
        op("lb103",   0, 1'b0, 3'b000, 32'h103, 32'h0, 32'h0000_0012, 1'b0);
        op("sw100b",  0, 1'b1, 3'b010, 32'h100, 32'h8001_1234, 32'h0, 1'b0);
        op("lh102",   0, 1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF_8001, 1'b0);
        op("lh103",   0, 1'b0, 3'b001, 32'h103, 32'h0, LH103, MIS_ERR);
        op("lw101",   0, 1'b0, 3'b010, 32'h101, 32'h0, LW101, MIS_ERR);
        op("sh101",   0, 1'b1, 3'b001, 32'h101, 32'h0000_BEEF, 32'h0, MIS_ERR);
        op("f3_011",  0, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1);
        op("sbu_wr",  0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1'b1);
        op("f3_110",  0, 1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1);
        op("f3_111w", 0, 1'b1, 3'b111, 32'h100, 32'h0, 32'h0, 1'b1);
        op("lw_fin",  0, 1'b0, 3'b010, 32'h100, 32'h0, WORD_FIN, 1'b0);
        op("sw1000",  0, 1'b1, 3'b010, 32'h1000, 32'hA5A5_A5A5, 32'h0, 1'b0);
        op("lw0wrap", 0, 1'b0, 3'b010, 32'h0, 32'h0, 32'hA5A5_A5A5, 1'b0);
        op("lwhiwrap",0, 1'b0, 3'b010, 32'hFFFF_F100, 32'h0, WORD_FIN, 1'b0);

        // LATENCY=3 instance: exact response timing and back-to-back accept
        op("l3.sw10", 1, 1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0);
        @(negedge clk);
        req_valid_a[1]  = 1'b1;
        req_write_a[1]  = 1'b0;
        req_funct3_a[1] = 3'b010;
        req_addr_a[1]   = 32'h10;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("l3.ready_n%0d", k), {31'b0, req_ready_a[1]}, 32'd0);
            check($sformatf("l3.valid_n%0d", k), {31'b0, rsp_valid_a[1]}, {31'b0, k == 3});
        end
        check("l3.rdata", rsp_rdata_a[1], 32'hCAFE_F00D);
        @(negedge clk);
        check("l3.ready_n4", {31'b0, req_ready_a[1]}, 32'd1);
        @(posedge clk);
        #1;
        req_valid_a[1] = 1'b0;
        @(negedge clk);
        check("l3.reaccept", {31'b0, req_ready_a[1]}, 32'd0);
        repeat (2) @(negedge clk);
        check("l3.valid2", {31'b0, rsp_valid_a[1]}, 32'd1);
        check("l3.rdata2", rsp_rdata_a[1], 32'hCAFE_F00D);
        @(posedge clk);

        // LATENCY=2 instance: reset abandons an in-flight store
        op("l2.sw200", 2, 1'b1, 3'b010, 32'h200, 32'h1234_5678, 32'h0, 1'b0);
        @(negedge clk);
        req_valid_a[2]  = 1'b1;
        req_write_a[2]  = 1'b1;
        req_funct3_a[2] = 3'b010;
        req_addr_a[2]   = 32'h200;
        req_wdata_a[2]  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        req_valid_a[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("l2.rst_ready", {31'b0, req_ready_a[2]}, 32'd1);
        check("l2.rst_valid", {31'b0, rsp_valid_a[2]}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid_a[2]) seen++;
        end
        check("l2.no_rsp", 32'(seen), 32'd0);
        op("l2.lw200",  2, 1'b0, 3'b010, 32'h200, 32'h0, 32'h1234_5678, 1'b0);
        op("l2.f3_011", 2, 1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 1'b1);
        op("l1.after_rst", 0, 1'b0, 3'b010, 32'h0, 32'h0, 32'hA5A5_A5A5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
